// File: rtl/sw_tail_collector.sv
// sw_tail_collector: consumes the last PE's per-cycle outputs of the Smith-Waterman
// array, tracks the best local-alignment score (value, column, pass) and buffers the
// boundary column (newline, t, V, F) in a FIFO for replay into the head-of-array feeder.
// Latency: max tracking and done are 1 cycle; a pushed entry is visible on out_* the
// cycle after its capture (no bypass). Backpressure: out_valid/out_ready on the replay
// side; when the FIFO is full a capture is dropped (sticky overflow) unless a pop
// frees a slot in the same cycle. full lets the controller raise the array lock.
//
// Ports:
//   clk, rst (async, active-low), enable (low = synchronous clear), lock (freeze capture)
//   in_*      last-PE outputs; in_valid qualifies a real cell, in_last ends a pass
//   pass_last final S segment: capture is tracked but not buffered
//   out_*     replay FIFO head, valid/ready handshake
//   full, overflow, max_score/max_col/max_pass, done (final pass complete pulse)
module sw_tail_collector #(
  parameter int VBIT  = 16,
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int PW    = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            lock,
  input  logic            in_valid,
  input  logic            in_newline,
  input  logic            in_last,
  input  logic [1:0]      in_t,
  input  logic [VBIT-1:0] in_v,
  input  logic [VBIT-1:0] in_f,
  input  logic            pass_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_newline,
  output logic [1:0]      out_t,
  output logic [VBIT-1:0] out_v,
  output logic [VBIT-1:0] out_f,
  output logic            full,
  output logic            overflow,
  output logic [VBIT-1:0] max_score,
  output logic [AW-1:0]   max_col,
  output logic [PW-1:0]   max_pass,
  output logic            done
);

  localparam int CW = AW + 1;  // count must represent 0..DEPTH inclusive

  typedef struct packed {
    logic            nl;
    logic [1:0]      t;
    logic [VBIT-1:0] v;
    logic [VBIT-1:0] f;
  } entry_t;

  entry_t          mem [DEPTH];

  logic [AW-1:0]   col_q, col_d;
  logic [PW-1:0]   pass_q, pass_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            full_q, full_d;
  logic            ovf_q, ovf_d;
  logic [VBIT-1:0] max_v_q, max_v_d;
  logic [AW-1:0]   max_c_q, max_c_d;
  logic [PW-1:0]   max_p_q, max_p_d;
  logic            done_q, done_d;

  logic            capture;
  logic [AW-1:0]   idx;
  logic            pop;
  logic            push_req;
  logic            push_ok;
  logic            better;
  entry_t          head;
  entry_t          wr_ent;

  assign capture  = enable & ~lock & in_valid;
  assign idx      = in_newline ? '0 : col_q;
  assign out_valid = (cnt_q != '0);
  // A pop needs a non-empty FIFO, so push+pop on empty is a plain push (no bypass).
  assign pop      = out_valid & out_ready & enable;
  assign push_req = capture & ~pass_last;
  // A same-cycle pop frees the slot the push needs, so a full FIFO still accepts.
  assign push_ok  = push_req & ((cnt_q != CW'(DEPTH)) | pop);
  assign better   = $signed(in_v) > $signed(max_v_q);
  assign wr_ent   = '{nl: in_newline, t: in_t, v: in_v, f: in_f};

  always_comb begin
    col_d   = col_q;
    pass_d  = pass_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    max_v_d = max_v_q;
    max_c_d = max_c_q;
    max_p_d = max_p_q;
    done_d  = 1'b0;

    if (!enable) begin
      col_d   = '0;
      pass_d  = '0;
      wptr_d  = '0;
      rptr_d  = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      max_v_d = '0;
      max_c_d = '0;
      max_p_d = '0;
    end else begin
      if (capture) begin
        col_d = idx + AW'(1);
        if (in_last && (pass_q != '1)) begin
          pass_d = pass_q + PW'(1);
        end
        // Strictly greater: ties keep the earlier position.
        if (better) begin
          max_v_d = in_v;
          max_c_d = idx;
          max_p_d = pass_q;
        end
        done_d = in_last & pass_last;
      end

      if (push_req && !push_ok) begin
        ovf_d = 1'b1;
      end
      if (push_ok) begin
        wptr_d = wptr_q + AW'(1);
      end
      if (pop) begin
        rptr_d = rptr_q + AW'(1);
      end
      case ({push_ok, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
    full_d = (cnt_d == CW'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q   <= '0;
      pass_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      max_v_q <= '0;
      max_c_q <= '0;
      max_p_q <= '0;
      done_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      pass_q  <= pass_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
      max_v_q <= max_v_d;
      max_c_q <= max_c_d;
      max_p_q <= max_p_d;
      done_q  <= done_d;
    end
  end

  // Storage is not reset; out_* are masked by out_valid so stale data never leaks.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr_q] <= wr_ent;
    end
  end

  assign head        = mem[rptr_q];
  assign out_newline = out_valid & head.nl;
  assign out_t       = out_valid ? head.t : 2'b00;
  assign out_v       = out_valid ? head.v : '0;
  assign out_f       = out_valid ? head.f : '0;

  assign full      = full_q;
  assign overflow  = ovf_q;
  assign max_score = max_v_q;
  assign max_col   = max_c_q;
  assign max_pass  = max_p_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sw_tail_collector.sv
module tb_sw_tail_collector;

  localparam int VBIT  = 16;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int PW    = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            enable;
  logic            lock;
  logic            in_valid;
  logic            in_newline;
  logic            in_last;
  logic [1:0]      in_t;
  logic [VBIT-1:0] in_v;
  logic [VBIT-1:0] in_f;
  logic            pass_last;
  logic            out_valid;
  logic            out_ready;
  logic            out_newline;
  logic [1:0]      out_t;
  logic [VBIT-1:0] out_v;
  logic [VBIT-1:0] out_f;
  logic            full;
  logic            overflow;
  logic [VBIT-1:0] max_score;
  logic [AW-1:0]   max_col;
  logic [PW-1:0]   max_pass;
  logic            done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [2+2*VBIT:0] exp_q[$];

  sw_tail_collector #(.VBIT(VBIT), .DEPTH(DEPTH), .AW(AW), .PW(PW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .lock(lock),
    .in_valid(in_valid), .in_newline(in_newline), .in_last(in_last),
    .in_t(in_t), .in_v(in_v), .in_f(in_f), .pass_last(pass_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_newline(out_newline),
    .out_t(out_t), .out_v(out_v), .out_f(out_f),
    .full(full), .overflow(overflow), .max_score(max_score),
    .max_col(max_col), .max_pass(max_pass), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a pop happens at the next posedge whenever valid&ready are seen here.
  always @(negedge clk) begin
    if (rst && enable && out_valid && out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL replay_unexpected: got %0h expected none",
                 {out_newline, out_t, out_v, out_f});
      end else begin
        logic [2+2*VBIT:0] e;
        e = exp_q.pop_front();
        if ({out_newline, out_t, out_v, out_f} !== e) begin
          n_bad++;
          $display("FAIL replay_entry: got %0h expected %0h",
                   {out_newline, out_t, out_v, out_f}, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cap(input logic nl, input logic last, input logic [1:0] t,
                     input logic [VBIT-1:0] v, input logic [VBIT-1:0] f,
                     input logic exp_push);
    in_valid   = 1'b1;
    in_newline = nl;
    in_last    = last;
    in_t       = t;
    in_v       = v;
    in_f       = f;
    if (exp_push) exp_q.push_back({nl, t, v, f});
    step();
    in_valid   = 1'b0;
    in_newline = 1'b0;
    in_last    = 1'b0;
  endtask

  task automatic chk_max(input string name, input logic [VBIT-1:0] s,
                         input logic [AW-1:0] c, input logic [PW-1:0] p);
    chk({name, "_score"}, 64'(max_score), 64'(s));
    chk({name, "_col"},   64'(max_col),   64'(c));
    chk({name, "_pass"},  64'(max_pass),  64'(p));
  endtask

  initial begin
    rst = 1'b0; enable = 1'b1; lock = 1'b0; in_valid = 1'b0; in_newline = 1'b0;
    in_last = 1'b0; in_t = 2'd0; in_v = '0; in_f = '0; pass_last = 1'b0; out_ready = 1'b0;
    step(); step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk_max("rst_max", 16'd0, 2'd0, 8'd0);
    rst = 1'b1;
    step();

    // Single final pass: V=3,7,7,2 -> max 7 at col 1, done once, nothing buffered.
    pass_last = 1'b1;
    cap(1'b1, 1'b0, 2'd0, 16'd3, 16'd0, 1'b0);
    cap(1'b0, 1'b0, 2'd1, 16'd7, 16'd0, 1'b0);
    cap(1'b0, 1'b0, 2'd2, 16'd7, 16'd0, 1'b0);
    chk("t1_done_early", 64'(done), 64'd0);
    cap(1'b0, 1'b1, 2'd3, 16'd2, 16'd0, 1'b0);
    chk("t1_done_pulse", 64'(done), 64'd1);
    chk_max("t1_max", 16'd7, 2'd1, 8'd0);
    chk("t1_out_valid", 64'(out_valid), 64'd0);
    step();
    chk("t1_done_clear", 64'(done), 64'd0);

    // Soft clear.
    enable = 1'b0;
    step();
    chk_max("en_clr_max", 16'd0, 2'd0, 8'd0);
    enable = 1'b1;

    // Buffered pass 0: fill the 4-entry FIFO.
    pass_last = 1'b0;
    cap(1'b1, 1'b0, 2'd1, 16'd1, 16'd5, 1'b1);
    cap(1'b0, 1'b0, 2'd2, 16'd2, 16'd6, 1'b1);
    chk("t2_out_valid", 64'(out_valid), 64'd1);
    cap(1'b0, 1'b0, 2'd3, 16'd3, 16'd7, 1'b1);
    chk("t2_full_3", 64'(full), 64'd0);
    cap(1'b0, 1'b1, 2'd0, 16'd4, 16'd8, 1'b1);
    chk("t2_full_4", 64'(full), 64'd1);
    chk_max("t2_max", 16'd4, 2'd3, 8'd0);

    // Full FIFO, push with simultaneous pop: accepted, still full, no overflow.
    // Column wrapped to 0, pass is now 1.
    out_ready = 1'b1;
    cap(1'b0, 1'b0, 2'd2, 16'd6, 16'd9, 1'b1);
    out_ready = 1'b0;
    chk("t3_full_pp", 64'(full), 64'd1);
    chk("t3_ovf_pp", 64'(overflow), 64'd0);
    chk_max("t3_max_wrap", 16'd6, 2'd0, 8'd1);

    // Full FIFO, push without pop: dropped, sticky overflow.
    cap(1'b0, 1'b0, 2'd1, 16'd5, 16'd1, 1'b0);
    chk("t3_ovf_set", 64'(overflow), 64'd1);
    chk("t3_full_drop", 64'(full), 64'd1);
    step();
    chk("t3_ovf_sticky", 64'(overflow), 64'd1);

    // Lock: inputs frozen, pops continue.
    lock = 1'b1; in_valid = 1'b1; in_v = 16'd100; in_f = 16'd3; out_ready = 1'b1;
    step(); step(); step();
    lock = 1'b0; in_valid = 1'b0;
    chk("t4_max_locked", 64'(max_score), 64'd6);
    chk("t4_full", 64'(full), 64'd0);
    chk("t4_out_valid", 64'(out_valid), 64'd1);
    step();
    out_ready = 1'b0;
    chk("t4_drained", 64'(out_valid), 64'd0);
    chk("t4_queue_empty", 64'(exp_q.size()), 64'd0);

    // Soft clear also clears overflow.
    enable = 1'b0;
    step();
    chk("en_clr_ovf", 64'(overflow), 64'd0);
    chk("en_clr_valid", 64'(out_valid), 64'd0);
    enable = 1'b1;

    // Multi-pass max tracking.
    pass_last = 1'b1;
    cap(1'b1, 1'b0, 2'd0, 16'd2, 16'd0, 1'b0);
    cap(1'b0, 1'b0, 2'd0, 16'd7, 16'd0, 1'b0);
    cap(1'b0, 1'b1, 2'd0, 16'd1, 16'd0, 1'b0);
    chk_max("t5_p0", 16'd7, 2'd1, 8'd0);
    cap(1'b1, 1'b0, 2'd0, 16'd3, 16'd0, 1'b0);
    cap(1'b0, 1'b0, 2'd0, 16'd4, 16'd0, 1'b0);
    cap(1'b0, 1'b1, 2'd0, 16'd9, 16'd0, 1'b0);
    chk_max("t5_p1", 16'd9, 2'd2, 8'd1);
    cap(1'b1, 1'b0, 2'd0, 16'hFFFB, 16'd0, 1'b0);
    cap(1'b0, 1'b0, 2'd0, 16'd9, 16'd0, 1'b0);
    cap(1'b0, 1'b1, 2'd0, 16'd9, 16'd0, 1'b0);
    chk_max("t5_tie", 16'd9, 2'd2, 8'd1);

    // Async reset mid-pass.
    pass_last = 1'b0;
    cap(1'b1, 1'b0, 2'd1, 16'd11, 16'd2, 1'b1);
    cap(1'b0, 1'b0, 2'd2, 16'd12, 16'd3, 1'b1);
    #3;
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_out_v", 64'(out_v), 64'd0);
    chk_max("arst_max", 16'd0, 2'd0, 8'd0);
    step();
    rst = 1'b1;
    step();
    chk("arst_full", 64'(full), 64'd0);
    chk("arst_ovf", 64'(overflow), 64'd0);
    chk("arst_valid_after", 64'(out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sw_tail_collector.md
Name: sw_tail_collector

Overview:
Sits at the output end of the Smith-Waterman systolic PE array and consumes the last PE's per-cycle outputs (newline, t, V, F). It tracks the running best local-alignment score and its position. When S is longer than the array, it buffers the boundary column (V, F, t, newline) in a FIFO and replays it to the head-of-array feeder on the next pass. It asserts full so the controller can raise the array lock.

Parameters:
VBIT, 16, width of V/E/F score values (two's complement, same as array datapath)
DEPTH, 256, boundary-column FIFO entries (max T length per pass)
AW, 8, FIFO address / column-index width, DEPTH = 2**AW
PW, 8, pass counter width

Ports:
clk  in  1  clock
rst  in  1  reset
enable  in  1  array enable; low = synchronous soft clear
lock  in  1  array lock; high = inputs frozen, no capture
in_valid  in  1  last-PE output is a real cell (pipeline filled)
in_newline  in  1  last PE newLineOut; first T char of a pass
in_last  in  1  last T char of the pass
in_t  in  2  last PE tOut
in_v  in  VBIT  last PE vOut
in_f  in  VBIT  last PE fOut
pass_last  in  1  current pass is the final S segment; do not buffer column
out_valid  out  1  replay entry available
out_ready  in  1  feeder consumes replay entry
out_newline  out  1  replayed newline
out_t  out  2  replayed t
out_v  out  VBIT  replayed V (feeder's vIn)
out_f  out  VBIT  replayed F (feeder's fIn)
full  out  1  FIFO holds DEPTH entries
overflow  out  1  sticky; a capture was dropped
max_score  out  VBIT  best V seen
max_col  out  AW  column index of max_score
max_pass  out  PW  pass index of max_score
done  out  1  one-cycle pulse, final pass complete

Behaviour:
- Reset is asynchronous, active-low (rst), on clock clk. All outputs reset to 0. The FIFO is emptied and the column and pass counters are cleared.
- enable=0 (synchronous, every cycle): same state as reset, except overflow is also cleared. Outputs are 0.
- capture = enable & ~lock & in_valid. No state changes on the capture path when capture=0.
- Column counter col (AW bits):
  - On capture with in_newline=1, the sample index is 0 and col becomes 1.
  - Otherwise the sample index is col and col increments.
  - col wraps modulo 2**AW.
- Pass counter pass_cnt:
  - Increments on capture with in_last=1.
  - Samples use the pre-increment value.
  - Saturates at all-ones.
- Max tracking:
  - On capture, if signed in_v > max_score, update max_score, max_col (sample index) and max_pass on the next edge.
  - Ties keep the earlier position.
  - Latency is 1 cycle.
- FIFO push:
  - A push is requested on capture & ~pass_last and writes {in_newline, in_t, in_v, in_f}.
  - The push is accepted if count < DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the sample is dropped and overflow is set.
- FIFO pop:
  - Pops on out_valid & out_ready.
  - out_* present the head entry combinationally from registered storage.
  - out_valid = (count != 0).
  - Pop while empty is ignored.
- Pointers wrap modulo DEPTH.
- full = (count == DEPTH), registered-equivalent and updated on the same edge as count.
- Simultaneous push and pop:
  - When empty, the entry passes through the FIFO; out_valid rises the cycle after, and no bypass is permitted.
  - When full, count is unchanged and there is no overflow.
- done pulses 1 cycle after a capture with in_last=1 and pass_last=1.
- lock=1 or enable=0 in the same cycle as in_valid: no capture, no push, no max update.
- Pops still proceed while lock=1.

Test Plan:
- Single pass with pass_last=1, 4 captures, V=3,7,7,2, newline on the first and in_last on the 4th -> max_score=7, max_col=1, max_pass=0, done pulses once one cycle after the 4th capture, out_valid stays 0.
- Two passes with DEPTH=4, pass 0 pass_last=0, V=1,2,3,4 with F=5,6,7,8 -> full=1 after the 4th capture; pop 4 with out_ready=1 -> replay (1,5),(2,6),(3,7),(4,8) in order with newline on the first only, then full=0 and out_valid=0.
- FIFO full and a 5th capture with out_ready=0 -> sample dropped, overflow=1 and stays 1; repeat with out_ready=1 in the same cycle -> accepted, count stays 4, overflow stays 0.
- lock=1 for 3 cycles with in_valid=1 and V=100 -> max_score, col and count unchanged, while a pending pop with out_ready=1 still completes.
- Pass 1 with max V=9 at col 2, after pass 0 max 7 -> max_pass=1, max_col=2; an equal V=9 at pass 2 does not update.
- Async rst low mid-pass, and separately enable=0 -> all outputs 0, FIFO empty, overflow cleared (enable) or reset (rst).
